dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane_sel.sv | 50 +++++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the wait-state counter width.
package dmem_pkg;

  localparam int WCNT_W = 4;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane_sel.sv
// Byte-lane steering: turns an address offset and access size into write
// strobes, lane-replicated store data and right-aligned load data.
module dmem_lane_sel
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strobe,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_align,
  output logic        misalign
);

  // Lane selection per size; the reserved size selects no lanes.
  always_comb begin
    strobe      = 4'b0000;
    wdata_lane  = 32'h0000_0000;
    rdata_align = 32'h0000_0000;
    misalign    = 1'b0;
    case (size)
      SIZE_B: begin
        strobe      = 4'b0001 << addr_lo;
        wdata_lane  = {4{wdata[7:0]}};
        rdata_align = {24'h00_0000, rword[{addr_lo, 3'b000} +: 8]};
        misalign    = 1'b0;
      end
      SIZE_H: begin
        strobe      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane  = {2{wdata[15:0]}};
        rdata_align = {16'h0000, rword[{addr_lo[1], 4'b0000} +: 16]};
        misalign    = addr_lo[0];
      end
      SIZE_W: begin
        strobe      = 4'b1111;
        wdata_lane  = wdata;
        rdata_align = rword;
        misalign    = |addr_lo;
      end
      default: begin
        strobe      = 4'b0000;
        wdata_lane  = 32'h0000_0000;
        rdata_align = 32'h0000_0000;
        misalign    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory answering core MEM-stage requests with a fixed
// number of wait states, a one-cycle ack and fault reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned       IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]       LIMIT     = 33'(DEPTH_WORDS) << 2;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_CYCLES);

  state_e            state_r, state_next_s;
  logic [WCNT_W-1:0] wcnt_r, wcnt_next_s;
  logic              accept_s;

  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [1:0]        size_r;

  logic              ready_r, ack_r, err_r;
  logic [31:0]       rdata_r;

  logic              idle_s;
  logic              acc_we_s;
  logic [31:0]       acc_addr_s, acc_wdata_s;
  logic [1:0]        acc_size_s;
  logic [31:0]       off_s;
  logic [IDX_W-1:0]  idx_s;
  logic              fault_s, wr_en_s;
  logic [3:0]        strobe_s;
  logic [31:0]       wdata_lane_s, rdata_align_s, rword_s;
  logic              misalign_s;

  logic [31:0]       mem [DEPTH_WORDS];

  // While idle the live inputs are decoded so a zero-wait access can respond
  // on the acceptance edge; afterwards the captured copy is used.
  assign idle_s      = (state_r == IDLE);
  assign acc_we_s    = idle_s ? i_we    : we_r;
  assign acc_addr_s  = idle_s ? i_addr  : addr_r;
  assign acc_wdata_s = idle_s ? i_wdata : wdata_r;
  assign acc_size_s  = idle_s ? i_size  : size_r;

  assign off_s   = acc_addr_s - BASE_ADDR;
  assign idx_s   = off_s[IDX_W+1:2];
  assign rword_s = mem[idx_s];
  assign fault_s = (acc_size_s == SIZE_RSVD) || misalign_s || ({1'b0, off_s} >= LIMIT);
  assign wr_en_s = (state_r == RESP) && we_r && !fault_s;

  dmem_lane_sel u_lane_sel (
    .addr_lo     (acc_addr_s[1:0]),
    .size        (acc_size_s),
    .wdata       (acc_wdata_s),
    .rword       (rword_s),
    .strobe      (strobe_s),
    .wdata_lane  (wdata_lane_s),
    .rdata_align (rdata_align_s),
    .misalign    (misalign_s)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    wcnt_next_s  = wcnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req) begin
          accept_s = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next_s = WAIT;
            wcnt_next_s  = WCNT_LOAD;
          end else begin
            state_next_s = RESP;
            wcnt_next_s  = {WCNT_W{1'b0}};
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (wcnt_r <= 4'd1) begin
          state_next_s = RESP;
          wcnt_next_s  = {WCNT_W{1'b0}};
        end else begin
          wcnt_next_s  = wcnt_r - 4'd1;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, counter and request capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      wcnt_r  <= {WCNT_W{1'b0}};
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      size_r  <= 2'b00;
    end else begin
      state_r <= state_next_s;
      wcnt_r  <= wcnt_next_s;
      if (accept_s) begin
        we_r    <= i_we;
        addr_r  <= i_addr;
        wdata_r <= i_wdata;
        size_r  <= i_size;
      end
    end
  end

  // Response outputs are loaded on the edge entering RESP and cleared otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b1;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= (state_next_s == IDLE);
      if (state_next_s == RESP) begin
        ack_r   <= 1'b1;
        err_r   <= fault_s;
        rdata_r <= (fault_s || acc_we_s) ? 32'h0000_0000 : rdata_align_s;
      end else begin
        ack_r   <= 1'b0;
        err_r   <= 1'b0;
        rdata_r <= 32'h0000_0000;
      end
    end
  end

  // Byte-lane write port; the array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && strobe_s[b]) begin
        mem[idx_s][8*b +: 8] <= wdata_lane_s[8*b +: 8];
      end
    end
  end

  assign o_ready = ready_r;
  assign o_ack   = ack_r;
  assign o_err   = err_r;
  assign o_rdata = rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table and randomized traffic on a
// one-wait-state instance, timing/base-address sequences on a three-wait one.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int A_DEPTH = 1024;
  localparam int A_LAT   = 2;
  localparam int B_LAT   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_req, a_we, a_ready, a_ack, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_size;
  logic        b_reset, b_req, b_we, b_ready, b_ack, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .reset(a_reset), .i_req(a_req), .i_we(a_we), .i_addr(a_addr),
    .i_wdata(a_wdata), .i_size(a_size), .o_ready(a_ready), .o_ack(a_ack),
    .o_rdata(a_rdata), .o_err(a_err));

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .reset(b_reset), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
    .i_wdata(b_wdata), .i_size(b_size), .o_ready(b_ready), .o_ack(b_ack),
    .o_rdata(b_rdata), .o_err(b_err));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed little-endian reference memory for instance A.
  logic [7:0] mb [0:4*A_DEPTH-1];

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, output logic [31:0] rd, output logic er);
    int nb;
    case (sz)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0) er = 1'b1;
    else         er = ((addr % nb) != 0) || (addr >= 32'(4 * A_DEPTH));
    rd = 32'h0;
    if (!er) begin
      for (int i = 0; i < nb; i++) begin
        if (we) mb[addr + i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mb[addr + i];
      end
    end
  endtask

  task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, output int lat, output logic [31:0] rd,
                          output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_ready_idle", a_ready, 1);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_size = sz;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'($urandom_range(0, 1)); a_addr = $urandom;
    a_wdata = $urandom; a_size = 2'($urandom_range(0, 3));
    chk("a_ready_busy", a_ready, 0);
    lat = 1;
    while (!a_ack && lat < 20) begin
      chk("a_err_no_ack", a_err, 0);
      chk("a_rdata_no_ack", a_rdata, 0);
      @(posedge clk); #1;
      lat++;
    end
    rd = a_rdata;
    er = a_err;
    @(posedge clk); #1;
    chk("a_ack_one_cycle", a_ack, 0);
  endtask

  task automatic access_b(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, output int lat, output logic [31:0] rd,
                          output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_size = sz;
    @(posedge clk); #1;
    b_req = 1'b0;
    lat = 1;
    while (!b_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b_rdata;
    er = b_err;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          lat;
    logic [31:0] rd, erd, addr, wd;
    logic        er, eer, we;
    logic [1:0]  sz;

    a_reset = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_size = 2'b00;
    b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_size = 2'b00;

    // Reset values
    @(posedge clk); #1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_ready", b_ready, 1);
    @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_a_ack", a_ack, 0);

    // Directed vectors on instance A
    tbl.push_back('{1'b1, 32'h010, 32'hDEAD_BEEF, SIZE_W, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_W, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h010, 32'h1122_3344, SIZE_W, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 32'h013, 32'h5A5A_5AA5, SIZE_B, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h013, 32'h0,         SIZE_B, 32'h0000_00A5, 1'b0});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_W, 32'hA522_3344, 1'b0});
    tbl.push_back('{1'b1, 32'h011, 32'hFFFF_FFFF, SIZE_H, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h102, 32'h0,         SIZE_W, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_RSVD, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h010, 32'h7777_7777, SIZE_RSVD, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_W, 32'hA522_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h012, 32'h0,         SIZE_H, 32'h0000_A522, 1'b0});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_H, 32'h0000_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h011, 32'h0,         SIZE_B, 32'h0000_0033, 1'b0});
    tbl.push_back('{1'b1, 32'h012, 32'hFFFF_BEEF, SIZE_H, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h010, 32'h0,         SIZE_W, 32'hBEEF_3344, 1'b0});
    tbl.push_back('{1'b1, 32'hFFC, 32'h0BAD_F00D, SIZE_W, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'hFFC, 32'h0,         SIZE_W, 32'h0BAD_F00D, 1'b0});
    tbl.push_back('{1'b0, 32'h1000, 32'h0,        SIZE_W, 32'h0, 1'b1});
    foreach (tbl[i]) begin
      access_a(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].sz, lat, rd, er);
      chk($sformatf("vec%0d_lat", i), lat, A_LAT);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), er, tbl[i].er);
    end

    // Reset during WAIT of a store aborts it
    access_a(1'b1, 32'h20, 32'hCAFE_F00D, SIZE_W, lat, rd, er);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h0; a_size = SIZE_W;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    a_reset = 1'b1;
    #1;
    chk("abort_ready", a_ready, 1);
    chk("abort_ack", a_ack, 0);
    @(negedge clk);
    a_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_ack%0d", c), a_ack, 0);
    end
    access_a(1'b0, 32'h20, 32'h0, SIZE_W, lat, rd, er);
    chk("abort_keep_data", rd, 32'hCAFE_F00D);
    chk("abort_keep_err", er, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 32; i++) begin
      wd = $urandom;
      model(1'b1, 32'(4 * i), wd, SIZE_W, erd, eer);
      access_a(1'b1, 32'(4 * i), wd, SIZE_W, lat, rd, er);
      chk("init_err", er, eer);
    end
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + 32'($urandom_range(0, 15));
        1:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: addr = 32'($urandom_range(0, 127));
      endcase
      wd = $urandom;
      model(we, addr, wd, sz, erd, eer);
      access_a(we, addr, wd, sz, lat, rd, er);
      chk($sformatf("rnd%0d_lat", i), lat, A_LAT);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_err", i), er, eer);
    end

    // Instance B: back-to-back requests with i_req held high
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h104; b_wdata = 32'h1234_5678; b_size = SIZE_W;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("b_ready_c%0d", c), b_ready, (c % 5 == 0));
      chk($sformatf("b_ack_c%0d", c), b_ack, (c % 5 == 4));
      @(negedge clk);
    end
    b_req = 1'b0;
    access_b(1'b0, 32'h104, 32'h0, SIZE_W, lat, rd, er);
    chk("b_load_lat", lat, B_LAT);
    chk("b_load_rdata", rd, 32'h1234_5678);
    chk("b_load_err", er, 0);
    access_b(1'b0, 32'h0FC, 32'h0, SIZE_W, lat, rd, er);
    chk("b_below_base_err", er, 1);
    chk("b_below_base_rdata", rd, 0);
    access_b(1'b0, 32'h200, 32'h0, SIZE_W, lat, rd, er);
    chk("b_above_top_err", er, 1);
    access_b(1'b1, 32'h1FC, 32'h600D_CAFE, SIZE_W, lat, rd, er);
    chk("b_top_store_err", er, 0);
    access_b(1'b0, 32'h1FE, 32'h0, SIZE_H, lat, rd, er);
    chk("b_top_half_rdata", rd, 32'h0000_600D);
    chk("b_top_half_err", er, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
